// File: rtl/mips_pkg.sv
// Shared types for the MIPS multiply/divide engine: operation codes, FSM states, width.
package mips_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'd0,
        MD_MULTU = 2'd1,
        MD_DIV   = 2'd2,
        MD_DIVU  = 2'd3
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } md_state_t;

    function automatic logic md_is_div(input md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_signed(input md_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/mult_div_unit_negate.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign fix.
module md_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + WIDTH'(1)) : i_val;

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle MULT/MULTU/DIV/DIVU engine with HI/LO registers: magnitudes are iterated
// for WIDTH cycles (shift-add or restoring divide), then signs are applied in FIX.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             Clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             hi_write,
    input  logic             lo_write,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    md_state_t          r_state, w_state_next;
    md_op_t             r_op;
    logic               r_q_neg, r_r_neg, r_dbz;
    logic [CW-1:0]      r_count;
    logic [WIDTH-1:0]   r_hi_acc, r_lo_acc, r_opnd;
    logic [WIDTH-1:0]   r_hi, r_lo;
    logic               r_done, r_dbz_pulse;

    md_op_t             w_op;
    logic               w_signed_in, w_is_div_in;
    logic [WIDTH-1:0]   w_rs_abs, w_rt_abs;
    logic [WIDTH:0]     w_sum, w_shifted;
    logic [WIDTH+1:0]   w_diff;
    logic [WIDTH-1:0]   w_hi_step, w_lo_step;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot_fix, w_rem_fix;

    assign w_op        = md_op_t'(op);
    assign w_signed_in = md_is_signed(w_op);
    assign w_is_div_in = md_is_div(w_op);

    md_negate #(.WIDTH(WIDTH)) u_neg_rs (
        .i_val(rs_val), .i_neg(w_signed_in & rs_val[WIDTH-1]), .o_val(w_rs_abs));
    md_negate #(.WIDTH(WIDTH)) u_neg_rt (
        .i_val(rt_val), .i_neg(w_signed_in & rt_val[WIDTH-1]), .o_val(w_rt_abs));
    md_negate #(.WIDTH(2*WIDTH)) u_neg_prod (
        .i_val({r_hi_acc, r_lo_acc}), .i_neg(r_q_neg), .o_val(w_prod_fix));
    md_negate #(.WIDTH(WIDTH)) u_neg_quot (
        .i_val(r_lo_acc), .i_neg(r_q_neg), .o_val(w_quot_fix));
    md_negate #(.WIDTH(WIDTH)) u_neg_rem (
        .i_val(r_hi_acc), .i_neg(r_r_neg), .o_val(w_rem_fix));

    // Multiply keeps the multiplier in the low half and shifts the sum in from the top;
    // divide shifts the dividend out of the low half into the partial remainder.
    assign w_sum     = {1'b0, r_hi_acc} + (r_lo_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_shifted = {r_hi_acc, r_lo_acc[WIDTH-1]};
    assign w_diff    = {1'b0, w_shifted} - {2'b00, r_opnd};

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        w_hi_step = r_hi_acc;
        w_lo_step = r_lo_acc;
        if (md_is_div(r_op)) begin
            if (!w_diff[WIDTH+1]) begin
                w_hi_step = w_diff[WIDTH-1:0];
                w_lo_step = {r_lo_acc[WIDTH-2:0], 1'b1};
            end else begin
                w_hi_step = w_shifted[WIDTH-1:0];
                w_lo_step = {r_lo_acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_hi_step = w_sum[WIDTH:1];
            w_lo_step = {w_sum[0], r_lo_acc[WIDTH-1:1]};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = (w_is_div_in && rt_val == '0) ? FIX : CALC;
            CALC:    if (r_count == '0) w_state_next = FIX;
            FIX:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign div_by_zero = r_dbz_pulse;
    assign hi          = r_hi;
    assign lo          = r_lo;

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op        <= MD_MULT;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_dbz       <= 1'b0;
            r_count     <= '0;
            r_hi_acc    <= '0;
            r_lo_acc    <= '0;
            r_opnd      <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_done      <= 1'b0;
            r_dbz_pulse <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_dbz_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op     <= w_op;
                        r_q_neg  <= w_signed_in & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                        r_r_neg  <= w_signed_in & rs_val[WIDTH-1];
                        r_dbz    <= w_is_div_in && (rt_val == '0);
                        r_count  <= CW'(WIDTH - 1);
                        r_hi_acc <= '0;
                        r_lo_acc <= w_is_div_in ? w_rs_abs : w_rt_abs;
                        r_opnd   <= w_is_div_in ? w_rt_abs : w_rs_abs;
                    end else begin
                        if (hi_write) r_hi <= wdata;
                        if (lo_write) r_lo <= wdata;
                    end
                end
                CALC: begin
                    r_hi_acc <= w_hi_step;
                    r_lo_acc <= w_lo_step;
                    r_count  <= r_count - CW'(1);
                end
                FIX: begin
                    r_done      <= 1'b1;
                    r_dbz_pulse <= r_dbz;
                    if (!r_dbz) begin
                        if (md_is_div(r_op)) begin
                            r_lo <= w_quot_fix;
                            r_hi <= w_rem_fix;
                        end else begin
                            {r_hi, r_lo} <= w_prod_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus randomized ops
// compared against a plain-arithmetic model of HI/LO.
module tb_mult_div_unit;
    import mips_pkg::*;

    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         reset_n;
    logic         start, hi_write, lo_write;
    logic [1:0]   op;
    logic [W-1:0] rs_val, rt_val, wdata;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    mult_div_unit #(.WIDTH(W)) dut (
        .Clk(Clk), .reset_n(reset_n), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .hi_write(hi_write), .lo_write(lo_write),
        .wdata(wdata), .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reference: what HI/LO/div_by_zero become, straight from the MIPS arithmetic rules.
    task automatic model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] e_hi, output logic [W-1:0] e_lo,
                         output logic e_dbz);
        longint      sa, sb;
        logic [63:0] p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e_hi = m_hi;
        e_lo = m_lo;
        e_dbz = 1'b0;
        case (o)
            2'd0: begin p = sa * sb; e_hi = p[63:32]; e_lo = p[31:0]; end
            2'd1: begin p = {32'b0, a} * {32'b0, b}; e_hi = p[63:32]; e_lo = p[31:0]; end
            default: begin
                if (b == '0) e_dbz = 1'b1;
                else if (o == 2'd2) begin
                    q = sa / sb; r = sa % sb; e_lo = q[31:0]; e_hi = r[31:0];
                end else begin
                    e_lo = a / b; e_hi = a % b;
                end
            end
        endcase
    endtask

    // Issue one operation and wait for done; optionally poke start/MT writes while busy
    // (at inject_cyc) or assert MT writes together with start.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int inject_cyc, input bit mt_with_start);
        logic [W-1:0] e_hi, e_lo;
        logic         e_dbz;
        int           n;
        bit           busy_ok;
        model(o, a, b, e_hi, e_lo, e_dbz);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        if (mt_with_start) begin
            hi_write = 1'b1; lo_write = 1'b1; wdata = $urandom;
        end
        tick();
        start = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
        rs_val = $urandom; rt_val = $urandom;
        n = 0;
        busy_ok = 1'b1;
        while (!done && n < 40) begin
            if (!busy) busy_ok = 1'b0;
            if (n == inject_cyc) begin
                start = 1'b1; op = 2'($urandom); rs_val = $urandom; rt_val = $urandom;
                hi_write = 1'b1; lo_write = 1'b1; wdata = $urandom;
            end
            tick();
            n++;
            start = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
        end
        check({tag, ".latency"}, 64'(n), e_dbz ? 64'd1 : 64'(W + 1));
        check({tag, ".busy_while_running"}, 64'(busy_ok), 64'd1);
        check({tag, ".busy_at_done"}, 64'(busy), 64'd0);
        check({tag, ".div_by_zero"}, 64'(div_by_zero), 64'(e_dbz));
        check({tag, ".hi"}, 64'(hi), 64'(e_hi));
        check({tag, ".lo"}, 64'(lo), 64'(e_lo));
        m_hi = e_hi;
        m_lo = e_lo;
    endtask

    task automatic mt_write(input string tag, input bit hw, input bit lw, input logic [W-1:0] d);
        hi_write = hw; lo_write = lw; wdata = d;
        tick();
        hi_write = 1'b0; lo_write = 1'b0;
        if (hw) m_hi = d;
        if (lw) m_lo = d;
        check({tag, ".hi"}, 64'(hi), 64'(m_hi));
        check({tag, ".lo"}, 64'(lo), 64'(m_lo));
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'd0;
            3:       return 32'd1;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset_n = 1'b0;
        start = 1'b0; hi_write = 1'b0; lo_write = 1'b0;
        op = '0; rs_val = '0; rt_val = '0; wdata = '0;
        repeat (3) tick();
        check("reset.hi", 64'(hi), 64'd0);
        check("reset.lo", 64'(lo), 64'd0);
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.done", 64'(done), 64'd0);
        check("reset.dbz", 64'(div_by_zero), 64'd0);
        reset_n = 1'b1;
        tick();

        run_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
        check("multu_max.hi_const", 64'(hi), 64'hFFFF_FFFE);
        check("multu_max.lo_const", 64'(lo), 64'h0000_0001);
        run_op("mult_neg3x5", MD_MULT, 32'hFFFF_FFFD, 32'd5, -1, 1'b0);
        run_op("mult_minxmin", MD_MULT, 32'h8000_0000, 32'h8000_0000, -1, 1'b0);
        run_op("div_neg7by2", MD_DIV, 32'hFFFF_FFF9, 32'd2, -1, 1'b0);
        run_op("divu_100by7", MD_DIVU, 32'd100, 32'd7, -1, 1'b0);
        run_op("div_wrap", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
        check("div_wrap.lo_const", 64'(lo), 64'h8000_0000);

        mt_write("mthi", 1'b1, 1'b0, 32'h11);
        mt_write("mtlo", 1'b0, 1'b1, 32'h22);
        run_op("divu_by0", MD_DIVU, 32'd100, 32'd0, -1, 1'b0);
        check("divu_by0.hi_const", 64'(hi), 64'h11);

        mt_write("mt_both", 1'b1, 1'b1, 32'h0);
        run_op("multu_ignore_busy", MD_MULTU, 32'd3, 32'd4, 10, 1'b0);
        run_op("start_beats_mt", MD_DIVU, 32'd1000, 32'd9, -1, 1'b1);

        // Reset in the middle of a divide must leave no partial result.
        start = 1'b1; op = MD_DIVU; rs_val = 32'd12345; rt_val = 32'd17;
        tick();
        start = 1'b0;
        repeat (14) tick();
        reset_n = 1'b0;
        #1;
        check("midreset.hi", 64'(hi), 64'd0);
        check("midreset.lo", 64'(lo), 64'd0);
        check("midreset.busy", 64'(busy), 64'd0);
        m_hi = '0;
        m_lo = '0;
        tick();
        reset_n = 1'b1;
        tick();
        run_op("multu_after_reset", MD_MULTU, 32'd2, 32'd3, -1, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0] ro;
            ro = 2'($urandom);
            if ($urandom_range(0, 5) == 0)
                mt_write("rand_mt", 1'($urandom), 1'($urandom), $urandom);
            run_op("rand", ro, pick_operand(), pick_operand(),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 30)) : -1,
                   1'($urandom_range(0, 7) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
